ftoi_wb_buffer: RTL and testbench
=================================

// Module: ftoi_wb_buffer
// PURPOSE
//  Writeback stage directly downstream of the combinational float->int converter.
//  Captures the converter's integer result, the destination tag, and its rounding/range flags.
//  Holds entries in a small FIFO until the register-file writeback port accepts them.
//  Accumulates sticky RISC-style exception flags (invalid, inexact) for the FCSR.
// PARAMETERS
//  DEPTH  2  FIFO entries; power of two, >=2
//  TAG_W  5  width of destination-register tag
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rstn         in   1      asynchronous active-low reset
//  in_valid     in   1      converter result + tag valid this cycle
//  in_ready     out  1      buffer can accept (not full)
//  in_d         in   32     converter integer result
//  in_tag       in   TAG_W  destination register
//  in_inf       in   1      converter out-of-range (saturated) flag
//  in_zero      in   1      converter forced-zero flag (|x|<0.5)
//  in_guard     in   1      converter guard bit
//  in_round     in   1      converter round bit
//  in_sticky    in   1      converter sticky bit
//  in_src_nz    in   1      source float nonzero (exp|mant != 0)
//  out_valid    out  1      head entry valid
//  out_ready    in   1      writeback consumes head
//  out_data     out  32     head integer result; 0 when out_valid=0
//  out_tag      out  TAG_W  head tag; 0 when out_valid=0
//  out_nx       out  1      head entry inexact
//  out_nv       out  1      head entry invalid
//  fflags       out  2      sticky {NV,NX}
//  fflags_clr   in   1      synchronous clear of fflags
// BEHAVIOUR
//  Reset (async, rstn=0): count=0, ptrs=0, fflags=0, out_valid=0, outputs 0, in_ready=1.
//  push = in_valid & in_ready; pop = out_valid & out_ready.
//  in_ready = (count != DEPTH), with no dependency on out_ready (no full-bypass).
//  out_valid = (count != 0), driven from registered state only.
//  Latency: a push into an empty buffer appears at out_* on the next cycle, never in the same cycle.
//  Per-entry flags are computed at push:
//    nv = in_inf
//    nx = ~in_inf & (in_zero ? in_src_nz : (in_guard|in_round|in_sticky))
//  Storage: mem[wr_ptr] <= {in_d,in_tag,nv,nx} on push.
//  Pointers: wr_ptr++ on push, rd_ptr++ on pop; both wrap modulo DEPTH.
//  count: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
//  Simultaneous push+pop when not full: both occur; ordering stays FIFO.
//  Pop when empty, or push when full: impossible by handshake; state unchanged.
//  fflags: next = (fflags_clr ? 0 : fflags) | (push ? {nv,nx} : 0).
//    A set from a push in the same cycle wins over fflags_clr.
//    Flags are set at accept time, not at pop.
//  in_* are ignored when in_valid=0; inputs held while stalled need not be stable.
//  Reset mid-operation discards all entries and flags immediately (asynchronous).
//  out_data/out_tag are masked to 0 when empty; stale mem content is never visible.
// TESTING
//  1. Reset, then push d=0x0000002A tag=3 (g=r=s=0) -> next cycle out_valid=1, data=0x2A, tag=3, nx=0, nv=0, fflags=00.
//  2. Push in_inf=1 d=0x80000000, then in_zero=1 src_nz=1 -> nv=1 on 1st, nx=1 on 2nd; fflags=11; fflags_clr -> 00.
//  3. out_ready=0, push 3 times (DEPTH=2) -> in_ready=0 after 2nd; 3rd held off; drain gives order 1,2 then 3.
//  4. count=1, push+pop same cycle for 8 cycles with incrementing d -> count stays 1, every value out in order across pointer wrap.
//  5. fflags_clr=1 together with a push of g=1 -> fflags=01 next cycle (set wins).
//  6. Assert rstn=0 with 2 entries queued -> out_valid=0, out_data=0, fflags=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/ftoi_wb_buffer_if.sv
// Handshake bundle between the float->int converter, the writeback buffer and
// the register-file writeback port.
interface ftoi_wb_buffer_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_d;
    logic [TAG_W-1:0] in_tag;
    logic             in_inf;
    logic             in_zero;
    logic             in_guard;
    logic             in_round;
    logic             in_sticky;
    logic             in_src_nz;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_nx;
    logic             out_nv;

    modport master (
        output in_valid, in_d, in_tag, in_inf, in_zero, in_guard, in_round,
               in_sticky, in_src_nz, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_nx, out_nv
    );

    modport slave (
        input  in_valid, in_d, in_tag, in_inf, in_zero, in_guard, in_round,
               in_sticky, in_src_nz, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_nx, out_nv
    );
endinterface

// File: rtl/ftoi_wb_buffer.sv
// Writeback FIFO behind the float->int converter: queues result/tag/flags until
// the register file accepts them, and accumulates sticky {NV,NX} for the FCSR.
module ftoi_wb_buffer #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input  logic            clk,
    input  logic            rstn,
    ftoi_wb_buffer_if.slave wb,
    output logic [1:0]      fflags,
    input  logic            fflags_clr
);
    localparam int DATA_W = 32;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    function automatic logic calc_nv(input logic inf);
        return inf;
    endfunction

    // A forced-zero result is inexact only if the source was nonzero; otherwise
    // any discarded bit makes it inexact. Saturated results report NV, never NX.
    function automatic logic calc_nx(input logic inf, input logic zero,
                                     input logic src_nz, input logic guard,
                                     input logic rnd, input logic sticky);
        return ~inf & (zero ? src_nz : (guard | rnd | sticky));
    endfunction

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] mem_d   [DEPTH];
    logic [TAG_W-1:0]  mem_tag [DEPTH];
    logic [DEPTH-1:0]  mem_nv;
    logic [DEPTH-1:0]  mem_nx;

    logic not_full;
    logic not_empty;
    logic vld_p0;
    logic pop;
    logic nv_p0;
    logic nx_p0;

    // Stage p0: accept decision and per-entry flags at the converter boundary
    assign not_full  = (count != FULL_CNT);
    assign not_empty = (count != '0);
    assign vld_p0    = wb.in_valid & not_full;
    assign pop       = not_empty & wb.out_ready;
    assign nv_p0     = calc_nv(wb.in_inf);
    assign nx_p0     = calc_nx(wb.in_inf, wb.in_zero, wb.in_src_nz,
                               wb.in_guard, wb.in_round, wb.in_sticky);

    always_ff @(posedge clk) begin
        if (vld_p0) begin
            mem_d[wr_ptr]   <= wb.in_d;
            mem_tag[wr_ptr] <= wb.in_tag;
            mem_nv[wr_ptr]  <= nv_p0;
            mem_nx[wr_ptr]  <= nx_p0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            fflags <= 2'b00;
        end else begin
            if (vld_p0) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({vld_p0, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A push in the same cycle as a clear still leaves its flags set
            fflags <= (fflags_clr ? 2'b00 : fflags) | (vld_p0 ? {nv_p0, nx_p0} : 2'b00);
        end
    end

    // Stage p1: registered head, masked so stale entries never leak out
    assign wb.in_ready  = not_full;
    assign wb.out_valid = not_empty;
    assign wb.out_data  = not_empty ? mem_d[rd_ptr]   : '0;
    assign wb.out_tag   = not_empty ? mem_tag[rd_ptr] : '0;
    assign wb.out_nv    = not_empty & mem_nv[rd_ptr];
    assign wb.out_nx    = not_empty & mem_nx[rd_ptr];
endmodule

// File: tb/tb_ftoi_wb_buffer.sv
// Scoreboard bench for ftoi_wb_buffer: inputs driven and outputs sampled on the
// falling clock edge, expected entries queued when a push is accepted.
module tb_ftoi_wb_buffer;
    localparam int DEPTH = 2;
    localparam int TAG_W = 5;

    typedef struct packed {
        logic [31:0]      d;
        logic [TAG_W-1:0] tag;
        logic             nv;
        logic             nx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] fflags;
    logic       fflags_clr;

    exp_t       sb[$];
    logic [1:0] exp_ff;
    int         n_cmp = 0;
    int         n_err = 0;

    ftoi_wb_buffer_if #(.TAG_W(TAG_W)) wb ();

    ftoi_wb_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .wb         (wb.slave),
        .fflags     (fflags),
        .fflags_clr (fflags_clr)
    );

    always #5 clk = ~clk;

    task automatic set_idle();
        wb.in_valid  = 1'b0;
        wb.in_d      = '0;
        wb.in_tag    = '0;
        wb.in_inf    = 1'b0;
        wb.in_zero   = 1'b0;
        wb.in_guard  = 1'b0;
        wb.in_round  = 1'b0;
        wb.in_sticky = 1'b0;
        wb.in_src_nz = 1'b0;
    endtask

    // Drives one converter result; if the buffer is ready it will be taken at
    // the next rising edge, so the expected entry and flags are recorded now.
    task automatic drive_push(input logic [31:0] d, input logic [TAG_W-1:0] tag,
                              input logic inf, input logic zero, input logic g,
                              input logic r, input logic s, input logic nz,
                              output logic acc);
        exp_t e;
        wb.in_valid  = 1'b1;
        wb.in_d      = d;
        wb.in_tag    = tag;
        wb.in_inf    = inf;
        wb.in_zero   = zero;
        wb.in_guard  = g;
        wb.in_round  = r;
        wb.in_sticky = s;
        wb.in_src_nz = nz;
        e.d   = d;
        e.tag = tag;
        e.nv  = inf;
        if (inf)       e.nx = 1'b0;
        else if (zero) e.nx = nz;
        else           e.nx = g | r | s;
        acc = wb.in_ready;
        if (acc) begin
            sb.push_back(e);
            exp_ff = exp_ff | {e.nv, e.nx};
        end
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        fflags_clr = 1'b0;
        wb.out_ready = 1'b0;
        set_idle();
        exp_ff = 2'b00;
        #1 rstn = 1'b0;
        #1;
        n_cmp++; if (wb.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", wb.out_valid); end
        n_cmp++; if (wb.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", wb.in_ready); end
        n_cmp++; if ({wb.out_data, wb.out_tag, wb.out_nv, wb.out_nx} !== '0) begin n_err++; $display("FAIL reset_outputs got=%h/%h/%b%b want=0", wb.out_data, wb.out_tag, wb.out_nv, wb.out_nx); end
        n_cmp++; if (fflags !== 2'b00) begin n_err++; $display("FAIL reset_fflags got=%b want=00", fflags); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        logic acc;
        exp_t e;
        @(negedge clk);
        drive_push(32'h0000002A, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        n_cmp++; if (wb.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_same_cycle out_valid got=%b want=0", wb.out_valid); end
        @(negedge clk);
        set_idle();
        n_cmp++; if (wb.out_valid !== 1'b1) begin n_err++; $display("FAIL basic_next_cycle out_valid got=%b want=1", wb.out_valid); end
        n_cmp++; if (fflags !== exp_ff) begin n_err++; $display("FAIL basic_fflags got=%b want=%b", fflags, exp_ff); end
        wb.out_ready = 1'b1;
        for (int i = 0; i < 8 && sb.size() > 0; i++) begin
            if (wb.out_valid) begin
                e = sb.pop_front();
                n_cmp++; if ({wb.out_data, wb.out_tag, wb.out_nv, wb.out_nx} !== e) begin n_err++; $display("FAIL basic_head got=%h/%0d/%b%b want=%h/%0d/%b%b", wb.out_data, wb.out_tag, wb.out_nv, wb.out_nx, e.d, e.tag, e.nv, e.nx); end
            end
            @(negedge clk);
        end
        wb.out_ready = 1'b0;
        n_cmp++; if (sb.size() != 0 || wb.out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain left=%0d out_valid=%b want 0/0", sb.size(), wb.out_valid); end
    endtask

    task automatic test_flags();
        logic acc;
        exp_t e;
        @(negedge clk);
        drive_push(32'h80000000, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        @(negedge clk);
        drive_push(32'h00000000, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        @(negedge clk);
        set_idle();
        n_cmp++; if (fflags !== exp_ff) begin n_err++; $display("FAIL flags_sticky got=%b want=%b", fflags, exp_ff); end
        wb.out_ready = 1'b1;
        for (int i = 0; i < 8 && sb.size() > 0; i++) begin
            if (wb.out_valid) begin
                e = sb.pop_front();
                n_cmp++; if ({wb.out_data, wb.out_tag, wb.out_nv, wb.out_nx} !== e) begin n_err++; $display("FAIL flags_head got=%h/%0d/%b%b want=%h/%0d/%b%b", wb.out_data, wb.out_tag, wb.out_nv, wb.out_nx, e.d, e.tag, e.nv, e.nx); end
            end
            @(negedge clk);
        end
        wb.out_ready = 1'b0;
        n_cmp++; if (fflags !== exp_ff) begin n_err++; $display("FAIL flags_after_pop got=%b want=%b", fflags, exp_ff); end
        fflags_clr = 1'b1;
        exp_ff = 2'b00;
        @(negedge clk);
        fflags_clr = 1'b0;
        n_cmp++; if (fflags !== exp_ff) begin n_err++; $display("FAIL flags_clear got=%b want=%b", fflags, exp_ff); end
    endtask

    task automatic test_full();
        logic acc;
        logic pend;
        exp_t e;
        @(negedge clk);
        drive_push(32'h1, 5'd11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        @(negedge clk);
        drive_push(32'h2, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
        @(negedge clk);
        drive_push(32'h3, 5'd13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        pend = ~acc;
        n_cmp++; if (wb.in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got=%b want=0", wb.in_ready); end
        repeat (2) @(negedge clk);
        n_cmp++; if (wb.out_data !== sb[0].d) begin n_err++; $display("FAIL full_hold_head got=%h want=%h", wb.out_data, sb[0].d); end
        wb.out_ready = 1'b1;
        for (int i = 0; i < 12 && (pend || sb.size() > 0); i++) begin
            if (wb.out_valid) begin
                e = sb.pop_front();
                n_cmp++; if ({wb.out_data, wb.out_tag, wb.out_nv, wb.out_nx} !== e) begin n_err++; $display("FAIL full_order got=%h/%0d/%b%b want=%h/%0d/%b%b", wb.out_data, wb.out_tag, wb.out_nv, wb.out_nx, e.d, e.tag, e.nv, e.nx); end
            end
            if (pend) begin
                drive_push(32'h3, 5'd13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
                pend = ~acc;
            end
            @(negedge clk);
            if (!pend) set_idle();
        end
        wb.out_ready = 1'b0;
        n_cmp++; if (pend || sb.size() != 0) begin n_err++; $display("FAIL full_drain pending=%b left=%0d want 0/0", pend, sb.size()); end
    endtask

    task automatic test_back_to_back();
        logic acc;
        exp_t e;
        @(negedge clk);
        drive_push(32'd100, 5'd20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (wb.out_valid !== 1'b1 || wb.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_count cycle=%0d out_valid=%b in_ready=%b want 1/1", i, wb.out_valid, wb.in_ready); end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++; if ({wb.out_data, wb.out_tag, wb.out_nv, wb.out_nx} !== e) begin n_err++; $display("FAIL b2b_head cycle=%0d got=%h/%0d/%b%b want=%h/%0d/%b%b", i, wb.out_data, wb.out_tag, wb.out_nv, wb.out_nx, e.d, e.tag, e.nv, e.nx); end
            end
            wb.out_ready = 1'b1;
            drive_push(32'd101 + 32'(i), 5'(21 + i), 1'b0, 1'b0, i[0], 1'b0, 1'b0, 1'b0, acc);
            @(negedge clk);
        end
        set_idle();
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++; if ({wb.out_data, wb.out_tag, wb.out_nv, wb.out_nx} !== e) begin n_err++; $display("FAIL b2b_last got=%h/%0d want=%h/%0d", wb.out_data, wb.out_tag, e.d, e.tag); end
        end
        @(negedge clk);
        wb.out_ready = 1'b0;
        n_cmp++; if (wb.out_valid !== 1'b0 || sb.size() != 0) begin n_err++; $display("FAIL b2b_drain out_valid=%b left=%0d want 0/0", wb.out_valid, sb.size()); end
    endtask

    task automatic test_clr_set();
        logic acc;
        exp_t e;
        @(negedge clk);
        drive_push(32'h7FFFFFFF, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        @(negedge clk);
        fflags_clr = 1'b1;
        exp_ff = 2'b00;
        drive_push(32'h00000005, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, acc);
        @(negedge clk);
        fflags_clr = 1'b0;
        set_idle();
        n_cmp++; if (fflags !== exp_ff) begin n_err++; $display("FAIL clr_set_wins got=%b want=%b", fflags, exp_ff); end
        wb.out_ready = 1'b1;
        for (int i = 0; i < 8 && sb.size() > 0; i++) begin
            if (wb.out_valid) begin
                e = sb.pop_front();
                n_cmp++; if ({wb.out_data, wb.out_tag, wb.out_nv, wb.out_nx} !== e) begin n_err++; $display("FAIL clr_head got=%h/%0d/%b%b want=%h/%0d/%b%b", wb.out_data, wb.out_tag, wb.out_nv, wb.out_nx, e.d, e.tag, e.nv, e.nx); end
            end
            @(negedge clk);
        end
        wb.out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        logic acc;
        @(negedge clk);
        drive_push(32'hDEADBEEF, 5'd30, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        @(negedge clk);
        drive_push(32'h12345678, 5'd31, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, acc);
        @(negedge clk);
        set_idle();
        n_cmp++; if (wb.out_valid !== 1'b1 || fflags !== exp_ff) begin n_err++; $display("FAIL areset_pre out_valid=%b fflags=%b want 1/%b", wb.out_valid, fflags, exp_ff); end
        #2 rstn = 1'b0;
        sb.delete();
        exp_ff = 2'b00;
        #1;
        n_cmp++; if (wb.out_valid !== 1'b0) begin n_err++; $display("FAIL areset_out_valid got=%b want=0", wb.out_valid); end
        n_cmp++; if (wb.out_data !== 32'h0 || wb.out_tag !== '0) begin n_err++; $display("FAIL areset_out_data got=%h/%0d want=0/0", wb.out_data, wb.out_tag); end
        n_cmp++; if (fflags !== exp_ff) begin n_err++; $display("FAIL areset_fflags got=%b want=%b", fflags, exp_ff); end
        n_cmp++; if (wb.in_ready !== 1'b1) begin n_err++; $display("FAIL areset_in_ready got=%b want=1", wb.in_ready); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        n_cmp++; if (wb.out_valid !== 1'b0) begin n_err++; $display("FAIL areset_after out_valid=%b want=0", wb.out_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_flags();
        test_full();
        test_back_to_back();
        test_clr_set();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
